// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, FSM state encoding and helpers for the rr_arbiter8 round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int NUM_REQ      = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;
    localparam int CNT_W        = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot      = '0;
        idx_to_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_prio_enc8.sv
// Rotated 8-input priority encoder: the first set bit of (req & ~excl) found when scanning
// upward from 'start' (mod 8) wins; 'any' flags that a winner exists.
module rr_prio_enc8
    import rr_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    input  logic [NUM_REQ-1:0] excl,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] masked;
    logic [IDX_W-1:0]   cand;

    // NOTE: every variable written in this always_comb is given a value up front so no path
    // leaves it unassigned; that is what keeps synthesis from inferring a latch.
    always_comb begin
        masked = req & ~excl;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        // Walk from the farthest offset down to 'start' so the nearest candidate is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = start + IDX_W'(i);
            if (masked[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and encoded index.
// Define RR_ARB_TIMEOUT_EN to compile in the MAX_HOLD forced-release feature.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;

    logic [IDX_W-1:0]   scan_start;
    logic [NUM_REQ-1:0] scan_excl;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               owner_held;
    logic               force_rel;
    logic               new_grant;

    rr_prio_enc8 u_enc (
        .req   (req),
        .start (scan_start),
        .excl  (scan_excl),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign owner_held = req[idx_q];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        gnt_d      = gnt_q;
        new_grant  = 1'b0;
        scan_start = ptr_q;
        scan_excl  = '0;

        if (state_q == ST_GRANT) begin
            scan_start = idx_q + 1'b1;
            if (force_rel) begin
                scan_excl = idx_to_onehot(idx_q);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d   = ST_GRANT;
                    idx_d     = win_idx;
                    gnt_d     = idx_to_onehot(win_idx);
                    new_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!owner_held || force_rel) begin
                    ptr_d = idx_q + 1'b1;
                    if (win_any) begin
                        idx_d     = win_idx;
                        gnt_d     = idx_to_onehot(win_idx);
                        new_grant = 1'b1;
                    end else if (force_rel) begin
                        // Nobody else is waiting: the revoked owner keeps the grant with a fresh budget.
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q;
    logic             timeout_q;

    assign force_rel = (state_q == ST_GRANT) && owner_held
                       && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (new_grant) begin
                hold_cnt_q <= '0;
            end else if (state_q == ST_GRANT) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    // MAX_HOLD only matters when the hold counter is built.
    localparam int unused_max_hold = MAX_HOLD;
    logic          unused_new_grant;

    assign unused_new_grant = new_grant;
    assign force_rel        = 1'b0;
    assign timeout          = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8; timeout scenarios run when RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [7:0] oh;
        oh = 8'h01 << idx;
        check({tag, ".gnt"}, gnt, oh);
        check({tag, ".idx"}, {5'b0, gnt_idx}, 8'(idx));
        check({tag, ".valid"}, {7'b0, gnt_valid}, 8'h01);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".gnt"}, gnt, 8'h00);
        check({tag, ".valid"}, {7'b0, gnt_valid}, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        req = 8'h00;
        do_reset();
        expect_idle("reset");
        check("reset.idx", {5'b0, gnt_idx}, 8'h00);
        check("reset.timeout", {7'b0, timeout}, 8'h00);

        // Single requester, one-cycle latency, release to idle
        req = 8'h01; step();
        expect_grant("single", 0);
        req = 8'h00; step();
        expect_idle("single_rel");
        // ptr is now 1: requester 1 beats requester 0
        req = 8'h03; step();
        expect_grant("ptr_moved", 1);
        req = 8'h00; step();
        expect_idle("ptr_rel");

        // Back-to-back owners with no gap cycle
        do_reset();
        req = 8'hA0; step();
        expect_grant("scan_a0", 5);
        req = 8'h80; step();
        expect_grant("b2b_7", 7);
        // Release of 7 with a fresh request from 2 on the same edge; scan wraps to 0
        req = 8'h04; step();
        expect_grant("wrap_2", 2);
        req = 8'h00; step();
        expect_idle("wrap_rel");

        // No preemption of the owner
        req = 8'h08; step();
        expect_grant("own3", 3);
        req = 8'h48; step();
        expect_grant("hold3_a", 3);
        step();
        expect_grant("hold3_b", 3);
        req = 8'h40; step();
        expect_grant("after3", 6);
        req = 8'h00; step();
        expect_idle("after3_rel");

        // Fairness under all-ones requests with release after two cycles
        do_reset();
        req = 8'hFF; step();
        for (int k = 0; k < 9; k++) begin
            expect_grant($sformatf("rr%0d", k), k % 8);
            step();
            expect_grant($sformatf("rr%0d_hold", k), k % 8);
            req = 8'hFF & ~(8'h01 << (k % 8));
            step();
            req = 8'hFF;
        end
        req = 8'h00; step();

        // Reset while a grant is active drops it regardless of req
        do_reset();
        req = 8'h20; step();
        expect_grant("pre_rst", 5);
        rst = 1'b1; step();
        expect_idle("mid_rst");
        check("mid_rst.idx", {5'b0, gnt_idx}, 8'h00);
        check("mid_rst.timeout", {7'b0, timeout}, 8'h00);
        rst = 1'b0;
        req = 8'h81; step();
        expect_grant("post_rst", 0);
        req = 8'h00; step();

`ifdef RR_ARB_TIMEOUT_EN
        // MAX_HOLD = 4: owner 0 revoked after four grant cycles in favour of 1
        do_reset();
        req = 8'h03;
        for (int c = 1; c <= 4; c++) begin
            step();
            expect_grant($sformatf("tmo_pair_c%0d", c), 0);
            check($sformatf("tmo_pair_c%0d.timeout", c), {7'b0, timeout}, 8'h00);
        end
        step();
        expect_grant("tmo_pair_switch", 1);
        check("tmo_pair_switch.timeout", {7'b0, timeout}, 8'h01);
        step();
        expect_grant("tmo_pair_after", 1);
        check("tmo_pair_after.timeout", {7'b0, timeout}, 8'h00);

        // Lone owner: periodic timeout pulses, same owner re-granted
        do_reset();
        req = 8'h01;
        for (int c = 1; c <= 12; c++) begin
            step();
            expect_grant($sformatf("tmo_solo_c%0d", c), 0);
            check($sformatf("tmo_solo_c%0d.timeout", c), {7'b0, timeout},
                  (c > 1 && (c % 4) == 1) ? 8'h01 : 8'h00);
        end
`else
        // Without the timeout feature the owner keeps the grant indefinitely
        do_reset();
        req = 8'h03;
        for (int c = 1; c <= 12; c++) begin
            step();
            expect_grant($sformatf("hold_c%0d", c), 0);
            check($sformatf("hold_c%0d.timeout", c), {7'b0, timeout}, 8'h00);
        end
`endif
        req = 8'h00; step();
        expect_idle("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters `a`..`h`, reusing the 8-input priority-encoding function as its selection core. It holds a rotating priority pointer, issues a one-hot grant plus a 3-bit encoded index, and keeps each grant until the owner releases its request. It sits in front of any shared datapath that previously took a fixed-priority `out2..out0` index directly.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per owner; used only when the timeout feature is compiled in; legal range 2..255.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; `req[0]` = a … `req[7]` = h.
- `gnt`  out  8  one-hot grant, registered.
- `gnt_idx`  out  3  encoded index of the granted requester; meaningful only while `gnt_valid` = 1.
- `gnt_valid`  out  1  high while any grant is active; equals `|gnt`.
- `timeout`  out  1  one-cycle pulse when a grant is force-revoked; constant 0 when the feature is compiled out.

## Operation
- State `IDLE`: no grant. On any clock edge where `req != 0`, select a winner, load `gnt`, `gnt_idx`, and `gnt_valid`, then go to `GRANT`.
- Selection: scan `ptr`, `ptr+1`, …, `ptr+7` (all mod 8). The first index with `req` high wins.
- State `GRANT`: hold `gnt` unchanged while `req[gnt_idx]` = 1. Requests from other requesters do not preempt the owner.
- Release: on an edge where `req[gnt_idx]` = 0, set `ptr <= gnt_idx + 1` (wraps 7→0).
  - If another request is pending, grant the winner of a scan starting at `gnt_idx + 1` on the same edge. There are no idle cycles between back-to-back owners.
  - Otherwise go to `IDLE` with `gnt` = 0.
- Fairness: under continuous all-ones `req` with per-owner release, the grant order is strictly cyclic. Every requester is served within 8 grants.
- Reset: at the next edge, `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0, `ptr` = 0, state `IDLE`, hold counter = 0. A reset during `GRANT` drops the grant immediately at that edge, regardless of `req`.
- `req` with X/Z is not supported. `req` is treated as already synchronous to `clk`.

## Timing
- Latency from request to grant: 1 cycle. `req` sampled at edge N produces `gnt` valid after edge N.
- Release to next grant: 1 cycle. `req[owner]` low at edge N means the new owner's `gnt` appears after edge N.
- All outputs are registered. There is no combinational path from `req` to any output.
- Simultaneous release and new request at the same edge: the new request competes in the scan from `gnt_idx + 1`.
- The releasing requester re-asserting on the next cycle has the lowest priority, because `ptr` has moved past it.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on each new grant and increments each `GRANT` cycle.
  - When it reaches `MAX_HOLD - 1` with `req[gnt_idx]` still high, the grant is revoked at the next edge: `ptr <= gnt_idx + 1`, `timeout` pulses 1, and a rescan excludes the current owner for that edge only.
  - If no other requester is pending, the same owner is re-granted, the counter restarts, and `timeout` still pulses.
- Not defined:
  - The counter logic is removed and `timeout` is tied 0.
  - A grant is held indefinitely while `req[gnt_idx]` stays high.

## Structure
- Shared package/header holds:
  - `NUM_REQ` = 8 and `IDX_W` = 3;
  - state encodings `ST_IDLE` = 1'b0 and `ST_GRANT` = 1'b1;
  - the default `MAX_HOLD`.
- Sub-module `rr_prio_enc8`: combinational rotated priority encoder.
  - Inputs: `req[7:0]`, `start[2:0]`, `excl[7:0]`.
  - Outputs: `idx[2:0]`, `any`.
  - Function: rotate by `start`, fixed-priority encode (lowest index first, matching the a>…>h ordering of the existing encoder), rotate back.
- The top level contains the FSM, `ptr`, hold counter, and output registers.

## Test plan
- Reset then `req` = 8'b0000_0001 → after 1 edge, `gnt` = 8'b0000_0001, `gnt_idx` = 0, `gnt_valid` = 1. Drop `req` → `gnt` = 0 next edge, `ptr` = 1.
- `ptr` = 0, `req` = 8'b1010_0000 → `gnt_idx` = 5. Release 5 while 7 is held → `gnt_idx` = 7 on the next edge, no gap cycle.
- `req` = 8'hFF held, each owner releasing after 2 cycles and re-requesting → grant order 0,1,2,…,7,0.
- Owner 3 granted, `req[6]` rises → `gnt` stays 8'b0000_1000 until `req[3]` falls, then `gnt_idx` = 6.
- `rst` asserted mid-grant (`gnt_idx` = 5) → next edge: all outputs 0, `ptr` = 0. Then `req` = 8'b1000_0001 → `gnt_idx` = 0.
- With `RR_ARB_TIMEOUT_EN`, `MAX_HOLD` = 4, `req` = 8'b0000_0011 held → owner 0 for 4 cycles, `timeout` pulse, then owner 1. With only `req[0]` held → `timeout` pulse every 4 cycles, `gnt_idx` stays 0.
